// File: rtl/countdown_timer_n_if.sv
// ---------------------------------------------------------------------------
// countdown_timer_n_if
// Purpose : bundles the control inputs and status outputs of countdown_timer_n
//           so a controller and the timer connect through one port.
// Signals :
//   ld       load strobe            (master -> slave)
//   ld_val   load value, W bits     (master -> slave)
//   start    start / restart        (master -> slave)
//   pause    level, freezes count   (master -> slave)
//   en       count step enable      (master -> slave)
//   auto_rl  auto-reload mode       (master -> slave)
//   q        current count, W bits  (slave -> master)
//   b        terminal count         (slave -> master)
//   busy     state is RUN or HOLD   (slave -> master)
//   done     state is DONE          (slave -> master)
// Modports: master = controller side, slave = timer side.
// ---------------------------------------------------------------------------
interface countdown_timer_n_if #(
    parameter int W = 4
);
    logic         ld;
    logic [W-1:0] ld_val;
    logic         start;
    logic         pause;
    logic         en;
    logic         auto_rl;
    logic [W-1:0] q;
    logic         b;
    logic         busy;
    logic         done;

    modport master (
        output ld, ld_val, start, pause, en, auto_rl,
        input  q, b, busy, done
    );

    modport slave (
        input  ld, ld_val, start, pause, en, auto_rl,
        output q, b, busy, done
    );
endinterface

// File: rtl/countdown_timer_n.sv
// ---------------------------------------------------------------------------
// countdown_timer_n
// Purpose : loadable modulo-N down-counter / timer. Counts down from a loaded
//           value, flags terminal count (q==0 while running) on b, and offers
//           start, pause, one-shot and auto-reload modes via a small FSM
//           (IDLE / RUN / HOLD / DONE).
// Parameters:
//   N  modulus, legal count values 0..N-1 (N >= 2)
//   W  counter width, 2**W >= N
// Ports :
//   clk   in  single clock, all state updates on posedge
//   rstn  in  synchronous active-low reset
//   tmr   slave modport of countdown_timer_n_if (controls in, status out)
// ---------------------------------------------------------------------------
module countdown_timer_n #(
    parameter int N = 12,
    parameter int W = 4
) (
    input  logic                clk,
    input  logic                rstn,
    countdown_timer_n_if.slave  tmr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [W-1:0] MAX_VAL = W'(N - 1);

    state_t       state_reg, state_next;
    logic [W-1:0] q_reg, q_next;
    logic [W-1:0] rl_reg, rl_next;
    logic [W-1:0] ld_clamped;

    // Out-of-range loads saturate to the top legal count.
    assign ld_clamped = (tmr.ld_val > MAX_VAL) ? MAX_VAL : tmr.ld_val;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            rl_reg    <= '0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            rl_reg    <= rl_next;
        end
    end

    // Edge priority: ld > pause > start > en. A paused request also blocks
    // start in IDLE/DONE, so pause is a universal freeze.
    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        rl_next    = rl_reg;
        if (tmr.ld) begin
            q_next     = ld_clamped;
            rl_next    = ld_clamped;
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Starting from zero would flag terminal count at once,
                    // so it is ignored.
                    if (!tmr.pause && tmr.start && (q_reg != '0)) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (tmr.pause) begin
                        state_next = HOLD;
                    end else if (tmr.en) begin
                        if (q_reg != '0) begin
                            q_next = q_reg - W'(1);
                        end else if (tmr.auto_rl && (rl_reg != '0)) begin
                            q_next = rl_reg;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
                HOLD: begin
                    // Resume without stepping on the release edge.
                    if (!tmr.pause) begin
                        state_next = RUN;
                    end
                end
                DONE: begin
                    if (!tmr.pause && tmr.start && (rl_reg != '0)) begin
                        q_next     = rl_reg;
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign tmr.q    = q_reg;
    assign tmr.b    = (state_reg == RUN) && (q_reg == '0);
    assign tmr.busy = (state_reg == RUN) || (state_reg == HOLD);
    assign tmr.done = (state_reg == DONE);

endmodule

// File: tb/tb_countdown_timer_n.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer_n
// Directed bench for countdown_timer_n (N=12, W=4). Inputs change 1ns after
// a rising edge and outputs are sampled there too; an independent checker
// verifies on every falling edge that b is never high with a nonzero count.
// ---------------------------------------------------------------------------
module tb_countdown_timer_n;

    localparam int N = 12;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rstn;
    int   n_assert = 0;
    int   n_fail   = 0;

    countdown_timer_n_if #(.W(W)) tif ();

    countdown_timer_n #(.N(N), .W(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .tmr  (tif.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // b must never be asserted while q is nonzero.
    always @(negedge clk) begin
        n_assert++;
        assert (!(tif.b === 1'b1 && tif.q !== '0)) else begin
            n_fail++;
            $error("FAIL b_with_nonzero_q observed=q%0d expected=q0 t=%0t", tif.q, $time);
        end
    end

    initial begin
        int cnt;
        int exp_q;

        rstn        = 1'b0;
        tif.ld      = 1'b0;
        tif.ld_val  = '0;
        tif.start   = 1'b0;
        tif.pause   = 1'b0;
        tif.en      = 1'b0;
        tif.auto_rl = 1'b0;

        // 1: reset, then start with nothing loaded stays IDLE
        #13;
        rstn = 1'b1;
        check("rst_q", 32'(tif.q), 0);
        check("rst_b", 32'(tif.b), 0);
        check("rst_busy", 32'(tif.busy), 0);
        check("rst_done", 32'(tif.done), 0);
        tif.start = 1'b1;
        tick();
        tif.start = 1'b0;
        check("start_q0_busy", 32'(tif.busy), 0);
        check("start_q0_q", 32'(tif.q), 0);

        // 2: one-shot from 5
        tif.ld_val = 4'd5;
        tif.ld     = 1'b1;
        tick();
        tif.ld = 1'b0;
        check("os_load_q", 32'(tif.q), 5);
        check("os_load_busy", 32'(tif.busy), 0);
        tif.start = 1'b1;
        tif.en    = 1'b1;
        tick();
        tif.start = 1'b0;
        check("os_start_q", 32'(tif.q), 5);
        check("os_start_busy", 32'(tif.busy), 1);
        check("os_start_b", 32'(tif.b), 0);
        for (int k = 4; k >= 0; k--) begin
            tick();
            check("os_q", 32'(tif.q), 32'(k));
            check("os_b", 32'(tif.b), (k == 0) ? 1 : 0);
        end
        tick();
        check("os_done", 32'(tif.done), 1);
        check("os_done_busy", 32'(tif.busy), 0);
        check("os_done_b", 32'(tif.b), 0);
        check("os_done_q", 32'(tif.q), 0);

        // 4: clamp 15 -> 11, first b 12 edges after start
        tif.ld_val = 4'd15;
        tif.ld     = 1'b1;
        tick();
        tif.ld = 1'b0;
        check("clamp_q", 32'(tif.q), 11);
        check("clamp_done_cleared", 32'(tif.done), 0);
        tif.start = 1'b1;
        tick();
        tif.start = 1'b0;
        cnt = 1;
        while (tif.b !== 1'b1 && cnt < 30) begin
            tick();
            cnt++;
        end
        check("clamp_edges_to_b", 32'(cnt), 12);
        check("clamp_b_q", 32'(tif.q), 0);

        // 3: auto-reload from 11 for 100 cycles
        tif.ld_val  = 4'd11;
        tif.ld      = 1'b1;
        tif.auto_rl = 1'b1;
        tick();
        tif.ld    = 1'b0;
        tif.start = 1'b1;
        tick();
        tif.start = 1'b0;
        exp_q = 11;
        check("ar_start_q", 32'(tif.q), 11);
        for (int i = 0; i < 100; i++) begin
            tick();
            exp_q = (exp_q == 0) ? 11 : exp_q - 1;
            check("ar_q", 32'(tif.q), 32'(exp_q));
            check("ar_b", 32'(tif.b), (exp_q == 0) ? 1 : 0);
        end
        check("ar_busy", 32'(tif.busy), 1);

        // 5: pause at q=3, then en toggling
        tif.ld_val  = 4'd6;
        tif.ld      = 1'b1;
        tif.auto_rl = 1'b0;
        tick();
        tif.ld    = 1'b0;
        tif.start = 1'b1;
        tick();
        tif.start = 1'b0;
        tick();
        tick();
        tick();
        check("pz_pre_q", 32'(tif.q), 3);
        tif.pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pz_q", 32'(tif.q), 3);
            check("pz_b", 32'(tif.b), 0);
            check("pz_busy", 32'(tif.busy), 1);
        end
        tif.pause = 1'b0;
        tick();
        check("pz_release_q", 32'(tif.q), 3);
        check("pz_release_busy", 32'(tif.busy), 1);
        tif.en = 1'b1; tick(); check("tg_q2", 32'(tif.q), 2);
        tif.en = 1'b0; tick(); check("tg_q2_hold", 32'(tif.q), 2);
        tif.en = 1'b1; tick(); check("tg_q1", 32'(tif.q), 1);
        tif.en = 1'b0; tick(); check("tg_q1_hold", 32'(tif.q), 1);
        tif.en = 1'b1; tick(); check("tg_q0", 32'(tif.q), 0);
        check("tg_b", 32'(tif.b), 1);
        tif.en = 1'b0; tick();
        check("tg_b_hold", 32'(tif.b), 1);
        check("tg_busy_hold", 32'(tif.busy), 1);
        tif.en = 1'b1; tick();
        check("tg_done", 32'(tif.done), 1);

        // 6a: DONE + start with rl=4 restarts at 4
        tif.ld_val = 4'd4;
        tif.ld     = 1'b1;
        tick();
        tif.ld    = 1'b0;
        tif.start = 1'b1;
        tick();
        tif.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("dr_done", 32'(tif.done), 1);
        tif.start = 1'b1;
        tick();
        tif.start = 1'b0;
        check("dr_q", 32'(tif.q), 4);
        check("dr_busy", 32'(tif.busy), 1);
        check("dr_done_clr", 32'(tif.done), 0);

        // 6b: reset mid-count at q=7
        tif.ld_val = 4'd7;
        tif.ld     = 1'b1;
        tick();
        tif.ld    = 1'b0;
        tif.start = 1'b1;
        tick();
        tif.start = 1'b0;
        check("mr_pre_q", 32'(tif.q), 7);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("mr_q", 32'(tif.q), 0);
        check("mr_busy", 32'(tif.busy), 0);
        check("mr_done", 32'(tif.done), 0);

        // 6c: ld and start on the same edge -> ld wins, IDLE
        tif.ld_val = 4'd9;
        tif.ld     = 1'b1;
        tif.start  = 1'b1;
        tick();
        tif.ld    = 1'b0;
        tif.start = 1'b0;
        check("ls_q", 32'(tif.q), 9);
        check("ls_busy", 32'(tif.busy), 0);
        tick();
        check("ls_q_idle", 32'(tif.q), 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
